// File: rtl/victim_cache_pkg.sv
// Shared types for the victim cache: line/tag types, index width, FSM states.
// Imported by the interface, the LRU tracker and the top.
package victim_cache_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;
    typedef logic [11:0]  lc3b_vc_tag;

    function automatic int vc_index_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    typedef enum logic [2:0] {
        VC_IDLE,
        VC_WB_DRAIN,
        VC_VC_WB,
        VC_MISS_READ,
        VC_RESPOND
    } vc_state_e;

endpackage

// File: rtl/victim_cache_if.sv
// L1-facing and pmem-facing bus of the victim cache.
// slave = the victim cache itself, master = the L1 + memory environment.
interface victim_cache_if;
    import victim_cache_pkg::*;

    logic          l1_read;
    logic          l1_write;
    logic          eviction;
    lc3b_word      l1_address;
    lc3b_cacheline l1_wdata;
    logic          l1_resp;
    lc3b_cacheline l1_rdata;
    logic          pmem_read;
    logic          pmem_write;
    lc3b_word      pmem_address;
    lc3b_cacheline pmem_wdata;
    lc3b_cacheline pmem_rdata;
    logic          pmem_resp;

    modport slave (
        input  l1_read, l1_write, eviction, l1_address, l1_wdata,
        input  pmem_rdata, pmem_resp,
        output l1_resp, l1_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output l1_read, l1_write, eviction, l1_address, l1_wdata,
        output pmem_rdata, pmem_resp,
        input  l1_resp, l1_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/victim_cache_lru.sv
// True-LRU over WAYS entries using age counters (0 = MRU, WAYS-1 = LRU).
// Reset order makes entry 0 the LRU.
module victim_lru
    import victim_cache_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int IW   = vc_index_w(WAYS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          touch_en,
    input  logic [IW-1:0] touch_idx,
    output logic [IW-1:0] lru_idx
);

    logic [IW-1:0] age_q [WAYS];
    logic [IW-1:0] age_d [WAYS];

    always_comb begin
        age_d = age_q;
        if (touch_en) begin
            for (int i = 0; i < WAYS; i++) begin
                if (age_q[i] < age_q[touch_idx]) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
            age_d[touch_idx] = '0;
        end
    end

    always_comb begin
        lru_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] == IW'(WAYS - 1)) begin
                lru_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= IW'(WAYS - 1 - i);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/victim_cache.sv
// Fully-associative victim cache between the L1 controller and pmem.
// Swap-on-hit reads, clean/dirty victim absorption, one-line holding buffer.
module victim_cache
    import victim_cache_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    victim_cache_if.slave  bus
);

    localparam int IW = vc_index_w(WAYS);

    vc_state_e     state_q, state_d;
    logic [WAYS-1:0] valid_q, valid_d;
    logic [WAYS-1:0] dirty_q, dirty_d;
    lc3b_vc_tag    tag_q  [WAYS];
    lc3b_vc_tag    tag_d  [WAYS];
    lc3b_cacheline data_q [WAYS];
    lc3b_cacheline data_d [WAYS];
    logic          hb_valid_q, hb_valid_d;
    lc3b_vc_tag    hb_tag_q, hb_tag_d;
    lc3b_cacheline hb_data_q, hb_data_d;
    lc3b_cacheline line_q, line_d;
    logic [IW-1:0] wb_idx_q, wb_idx_d;

    lc3b_vc_tag    req_tag;
    logic          hit, free;
    logic [IW-1:0] hit_idx, free_idx, lru_idx, tgt_idx;
    logic          tgt_dirty;
    logic          clean_ev, dirty_ev;
    logic          ins_en, ins_dirty;

    assign req_tag  = bus.l1_address[15:4];
    assign clean_ev = bus.eviction & ~bus.l1_write;
    assign dirty_ev = bus.eviction & bus.l1_write;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free     = 1'b1;
                free_idx = IW'(i);
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            if (valid_q[i] && tag_q[i] == req_tag) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Slot choice: tag match, then lowest free slot, then LRU.
    assign tgt_idx   = hit ? hit_idx : (free ? free_idx : lru_idx);
    assign tgt_dirty = valid_q[tgt_idx] & dirty_q[tgt_idx];

    victim_lru #(.WAYS(WAYS), .IW(IW)) u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .touch_en  (ins_en),
        .touch_idx (tgt_idx),
        .lru_idx   (lru_idx)
    );

    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        tag_d            = tag_q;
        data_d           = data_q;
        hb_valid_d       = hb_valid_q;
        hb_tag_d         = hb_tag_q;
        hb_data_d        = hb_data_q;
        line_d           = line_q;
        wb_idx_d         = wb_idx_q;
        ins_en           = 1'b0;
        ins_dirty        = 1'b0;
        bus.l1_resp      = 1'b0;
        bus.l1_rdata     = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;

        unique case (state_q)
            VC_IDLE: begin
                priority case (1'b1)
                    clean_ev: begin
                        ins_en = 1'b1;
                        if (tgt_dirty) begin
                            hb_valid_d = 1'b1;
                            hb_tag_d   = tag_q[tgt_idx];
                            hb_data_d  = data_q[tgt_idx];
                            state_d    = VC_WB_DRAIN;
                        end
                    end
                    dirty_ev: begin
                        if (tgt_dirty) begin
                            wb_idx_d = tgt_idx;
                            state_d  = VC_VC_WB;
                        end else begin
                            ins_en      = 1'b1;
                            ins_dirty   = 1'b1;
                            bus.l1_resp = 1'b1;
                        end
                    end
                    (bus.l1_read && !hb_valid_q): begin
                        if (hit) begin
                            bus.l1_resp      = 1'b1;
                            bus.l1_rdata     = data_q[hit_idx];
                            valid_d[hit_idx] = 1'b0;
                            dirty_d[hit_idx] = 1'b0;
                        end else begin
                            state_d = VC_MISS_READ;
                        end
                    end
                    default: ;
                endcase
            end
            VC_WB_DRAIN: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {hb_tag_q, 4'h0};
                bus.pmem_wdata   = hb_data_q;
                if (bus.pmem_resp) begin
                    hb_valid_d = 1'b0;
                    state_d    = VC_IDLE;
                end
            end
            VC_VC_WB: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[wb_idx_q], 4'h0};
                bus.pmem_wdata   = data_q[wb_idx_q];
                if (bus.pmem_resp) begin
                    dirty_d[wb_idx_q] = 1'b0;
                    state_d           = VC_IDLE;
                end
            end
            VC_MISS_READ: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {req_tag, 4'h0};
                if (bus.pmem_resp) begin
                    line_d  = bus.pmem_rdata;
                    state_d = VC_RESPOND;
                end
            end
            VC_RESPOND: begin
                bus.l1_resp  = 1'b1;
                bus.l1_rdata = line_q;
                state_d      = VC_IDLE;
            end
            default: state_d = VC_IDLE;
        endcase

        if (ins_en) begin
            valid_d[tgt_idx] = 1'b1;
            dirty_d[tgt_idx] = ins_dirty;
            tag_d[tgt_idx]   = req_tag;
            data_d[tgt_idx]  = bus.l1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= VC_IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            hb_valid_q <= 1'b0;
            hb_tag_q   <= '0;
            hb_data_q  <= '0;
            line_q     <= '0;
            wb_idx_q   <= '0;
            for (int i = 0; i < WAYS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            hb_valid_q <= hb_valid_d;
            hb_tag_q   <= hb_tag_d;
            hb_data_q  <= hb_data_d;
            line_q     <= line_d;
            wb_idx_q   <= wb_idx_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
        end
    end

    clean_ev_in_idle_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != VC_IDLE) |-> !clean_ev);

    pmem_excl_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.pmem_read && bus.pmem_write));

endmodule

// File: tb/tb_victim_cache.sv
// Randomized bench for victim_cache against a transaction-level model
// (entry arrays + LRU queue + pmem scoreboard).
module tb_victim_cache;
    import victim_cache_pkg::*;

    localparam int WAYS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    victim_cache_if bus();

    victim_cache #(.WAYS(WAYS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    bit          m_v [WAYS];
    bit          m_d [WAYS];
    logic [11:0] m_t [WAYS];
    logic [127:0] m_x [WAYS];
    int          lru_q[$];
    logic [15:0]  exp_wr_a[$];
    logic [127:0] exp_wr_d[$];
    logic [15:0]  exp_rd_a[$];
    int pmem_lat = 2;
    bit lat_rand = 1'b0;

    function automatic logic [127:0] mem_line(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5a5a, a + 16'h1234, 16'hc0de, a, 16'hbeef, ~a};
    endfunction

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void m_reset();
        lru_q = {};
        for (int i = 0; i < WAYS; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = 1'b0;
            lru_q.push_back(i);
        end
        exp_wr_a = {};
        exp_wr_d = {};
        exp_rd_a = {};
    endfunction

    function automatic int m_find(input logic [11:0] t);
        for (int i = 0; i < WAYS; i++)
            if (m_v[i] && m_t[i] == t) return i;
        return -1;
    endfunction

    function automatic int m_target(input logic [11:0] t);
        int h = m_find(t);
        if (h >= 0) return h;
        for (int i = 0; i < WAYS; i++)
            if (!m_v[i]) return i;
        return lru_q[0];
    endfunction

    function automatic void m_insert(input int w, input logic [11:0] t,
                                     input logic [127:0] d, input bit dirty);
        m_v[w] = 1'b1;
        m_d[w] = dirty;
        m_t[w] = t;
        m_x[w] = d;
        for (int k = 0; k < lru_q.size(); k++) begin
            if (lru_q[k] == w) begin
                lru_q.delete(k);
                break;
            end
        end
        lru_q.push_back(w);
    endfunction

    initial begin : pmem_model
        int cnt;
        cnt = 0;
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !(bus.pmem_read || bus.pmem_write)) begin
                cnt = 0;
                continue;
            end
            chk("pmem_excl", 128'(bus.pmem_read & bus.pmem_write), '0);
            cnt++;
            if (cnt >= pmem_lat) begin
                if (bus.pmem_write) begin
                    chk("wr_expected", 128'(exp_wr_a.size() != 0), 128'd1);
                    if (exp_wr_a.size() != 0) begin
                        chk("wr_addr", 128'(bus.pmem_address), 128'(exp_wr_a.pop_front()));
                        chk("wr_data", bus.pmem_wdata, exp_wr_d.pop_front());
                    end
                end else begin
                    chk("rd_expected", 128'(exp_rd_a.size() != 0), 128'd1);
                    if (exp_rd_a.size() != 0)
                        chk("rd_addr", 128'(bus.pmem_address), 128'(exp_rd_a.pop_front()));
                    bus.pmem_rdata = mem_line(bus.pmem_address);
                end
                bus.pmem_resp = 1'b1;
                @(posedge clk);
                #1;
                bus.pmem_resp = 1'b0;
                bus.pmem_rdata = '0;
                cnt = 0;
            end
        end
    end

    task automatic drive(input bit rd, input bit wr, input bit ev,
                         input logic [15:0] a, input logic [127:0] d);
        @(posedge clk);
        #1;
        bus.l1_read = rd;
        bus.l1_write = wr;
        bus.eviction = ev;
        bus.l1_address = a;
        bus.l1_wdata = d;
    endtask

    task automatic pick_lat();
        if (lat_rand && exp_wr_a.size() == 0) pmem_lat = $urandom_range(1, 4);
    endtask

    task automatic wait_resp(input string tag, input int exp_cyc, input bit is_rd,
                             input logic [127:0] exp_data);
        int cyc = 0;
        bit got = 1'b0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (bus.l1_resp) got = 1'b1;
            else if (is_rd) chk({tag, "_rdata_idle"}, bus.l1_rdata, '0);
        end
        chk({tag, "_done"}, 128'(got), 128'd1);
        chk({tag, "_lat"}, 128'(cyc), 128'(exp_cyc));
        if (is_rd && got) chk({tag, "_rdata"}, bus.l1_rdata, exp_data);
        if (!got) drive(0, 0, 0, '0, '0);
    endtask

    task automatic op_clean(input logic [15:0] a, input logic [127:0] d);
        int w;
        int guard = 0;
        while (exp_wr_a.size() != 0 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        chk("ce_drained", 128'(exp_wr_a.size()), '0);
        pick_lat();
        w = m_target(a[15:4]);
        if (m_v[w] && m_d[w]) begin
            exp_wr_a.push_back({m_t[w], 4'h0});
            exp_wr_d.push_back(m_x[w]);
        end
        m_insert(w, a[15:4], d, 1'b0);
        drive(0, 0, 1, a, d);
        @(negedge clk);
        chk("ce_resp", 128'(bus.l1_resp), '0);
        drive(0, 0, 0, '0, '0);
    endtask

    task automatic op_read(input logic [15:0] a);
        int w, pend, exp_cyc;
        logic [127:0] ed;
        pick_lat();
        pend = (exp_wr_a.size() != 0) ? pmem_lat - 1 : 0;
        w = m_find(a[15:4]);
        if (w >= 0) begin
            ed = m_x[w];
            m_v[w] = 1'b0;
            m_d[w] = 1'b0;
            exp_cyc = pend + 1;
        end else begin
            ed = mem_line({a[15:4], 4'h0});
            exp_rd_a.push_back({a[15:4], 4'h0});
            exp_cyc = pend + pmem_lat + 2;
        end
        drive(1, 0, 0, a, '0);
        wait_resp("rd", exp_cyc, 1'b1, ed);
    endtask

    task automatic op_dirty(input logic [15:0] a, input logic [127:0] d);
        int w, pend;
        bit wb;
        pick_lat();
        pend = (exp_wr_a.size() != 0) ? pmem_lat - 1 : 0;
        w = m_target(a[15:4]);
        wb = m_v[w] && m_d[w];
        if (wb) begin
            exp_wr_a.push_back({m_t[w], 4'h0});
            exp_wr_d.push_back(m_x[w]);
        end
        m_insert(w, a[15:4], d, 1'b1);
        drive(0, 1, 1, a, d);
        wait_resp("dw", pend + (wb ? pmem_lat + 2 : 1), 1'b0, '0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_l1_resp"}, 128'(bus.l1_resp), '0);
        chk({tag, "_l1_rdata"}, bus.l1_rdata, '0);
        chk({tag, "_pmem_rd"}, 128'(bus.pmem_read), '0);
        chk({tag, "_pmem_wr"}, 128'(bus.pmem_write), '0);
        chk({tag, "_pmem_addr"}, 128'(bus.pmem_address), '0);
        chk({tag, "_pmem_wdata"}, bus.pmem_wdata, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.l1_read = 1'b0;
        bus.l1_write = 1'b0;
        bus.eviction = 1'b0;
        bus.l1_address = '0;
        bus.l1_wdata = '0;
        m_reset();
        repeat (2) @(negedge clk);
        chk_outputs_zero("rst");
        #2 rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] la;
        bus.l1_read = 1'b0;
        bus.l1_write = 1'b0;
        bus.eviction = 1'b0;
        bus.l1_address = '0;
        bus.l1_wdata = '0;
        do_reset();

        la = rnd_line();
        op_clean(16'h1230, la);
        op_read(16'h1234);
        op_read(16'h1230);

        pmem_lat = 3;
        op_read(16'h4000);
        op_read(16'h4000);

        do_reset();
        pmem_lat = 2;
        for (int i = 1; i <= 4; i++) op_dirty(16'(i) << 12, rnd_line());
        op_dirty(16'h5000, rnd_line());
        op_read(16'h5008);
        op_dirty(16'h5000, rnd_line());
        op_clean(16'h6000, rnd_line());
        op_read(16'h7000);

        do_reset();
        for (int i = 1; i <= 4; i++) op_dirty(16'(i) << 12, rnd_line());
        la = rnd_line();
        op_read(16'h1000);
        op_clean(16'h1000, la);
        op_dirty(16'h8000, rnd_line());
        op_read(16'h2000);
        op_read(16'h1000);

        op_clean(16'h1230, rnd_line());
        pmem_lat = 4;
        drive(1, 0, 0, 16'h4440, '0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("mid_rst");
        bus.l1_read = 1'b0;
        m_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        op_read(16'h1230);

        lat_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            int sel;
            a = {12'h100 + 12'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            sel = $urandom_range(0, 99);
            if (sel < 45) op_read(a);
            else if (sel < 75) op_clean(a, rnd_line());
            else op_dirty(a, rnd_line());
        end

        drive(0, 0, 0, '0, '0);
        for (int g = 0; g < 64 && exp_wr_a.size() != 0; g++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("end_wr_queue", 128'(exp_wr_a.size()), '0);
        chk("end_rd_queue", 128'(exp_rd_a.size()), '0);
        chk_outputs_zero("end");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/victim_cache.md
Name: victim_cache

Overview:
- Fully-associative victim cache between the L1 cache controller and physical memory.
- Acts as the responder for the L1's downstream interface (l2_read/l2_write/eviction/l2_resp) and as an initiator towards pmem.
- Clean L1 victims are absorbed in one cycle with no handshake; dirty victims are absorbed with a response.
- L1 misses hit the victim cache with swap semantics (entry invalidated on hit) or are forwarded to pmem.

Parameters:
- WAYS, 4, number of entries; power of two, 2..8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- l1_read  in  1  line fetch request from L1; held until l1_resp
- l1_write  in  1  dirty-victim write from L1; held until l1_resp; always accompanied by eviction
- eviction  in  1  victim transfer; with l1_write=0 it is a one-cycle clean insert needing no response
- l1_address  in  16  byte address (lc3b_word); line tag = [15:4]
- l1_wdata  in  128  victim line (lc3b_cacheline)
- l1_resp  out  1  completion of a read or dirty write
- l1_rdata  out  128  read line, valid when l1_resp=1 on a read
- pmem_read  out  1  pmem line read request
- pmem_write  out  1  pmem line write request
- pmem_address  out  16  line address, [3:0]=0
- pmem_wdata  out  128  line written to pmem
- pmem_rdata  in  128  line read from pmem
- pmem_resp  in  1  pmem completion, one cycle

Behaviour:
- Storage per entry: valid, dirty, 12-bit tag, 128-bit data. A true-LRU order is kept over all WAYS entries.
- Reset (asynchronous): all valid/dirty = 0; LRU order = index order (entry 0 is LRU); holding buffer empty; state IDLE; all outputs 0.
- Target slot for an insert is chosen in this order:
  - the entry whose tag matches, if any;
  - else the lowest-index invalid entry;
  - else the LRU entry.
- An insert writes tag/data, sets valid, sets dirty = l1_write, and makes the slot MRU.

State IDLE:
- eviction & ~l1_write (clean insert):
  - Commit at this edge; l1_resp stays 0.
  - If the target is valid and dirty, its old contents move to the holding buffer first; next state WB_DRAIN.
- l1_write & eviction, target clean or invalid: insert at this edge; l1_resp=1 combinationally this cycle.
- l1_write & eviction, target dirty: l1_resp=0; go to VC_WB.
- l1_read, tag hit:
  - l1_resp=1 and l1_rdata = entry data combinationally this cycle.
  - The entry's valid/dirty are cleared at the edge (swap). LRU is not updated.
- l1_read, miss: go to MISS_READ.
- Request priority: eviction-carrying requests are processed before reads. A read arriving with holding buffer non-empty waits (cannot occur in IDLE by construction).

State WB_DRAIN:
- pmem_write=1, with pmem_address/pmem_wdata taken from the holding buffer.
- On pmem_resp: empty the buffer; go to IDLE.
- Any L1 request is stalled (l1_resp=0) while in this state.

State VC_WB:
- pmem_write=1 for the target entry.
- On pmem_resp: clear that entry's dirty bit; go to IDLE. The held l1_write then completes there because the target is now clean.

State MISS_READ:
- pmem_read=1; pmem_address = {l1_address[15:4],4'h0}.
- On pmem_resp: latch pmem_rdata; go to RESPOND.
- The fetched line is not installed in the victim cache.

State RESPOND:
- l1_resp=1 for exactly one cycle; l1_rdata = latched line; next state IDLE.

Protocol rules:
- A clean eviction outside IDLE is a protocol violation: it is ignored, and a simulation assertion fires.
- pmem_read and pmem_write are never both 1. Both hold steady until pmem_resp.
- l1_resp is never asserted in two consecutive cycles for the same request.
- l1_rdata = 0 whenever l1_resp=0.

Decomposition:
- Add to lc3b_types:
  - lc3b_vc_tag (12 bits);
  - vc_index width function of WAYS;
  - state enum for victim_cache.
- Sub-module victim_lru: WAYS-entry true-LRU (age counters) with touch(index) and lru_index output; asynchronous active-low reset to index order.

Test Plan:
1. Reset → clean eviction addr 0x1230 data A → l1_read 0x1234 the next cycle → l1_resp=1 the same cycle, l1_rdata=A, entry invalid afterwards; a second read of 0x1230 goes to pmem.
2. l1_read 0x4000 miss, pmem_resp after 3 cycles with data B → pmem_read high 3 cycles, then RESPOND with l1_resp=1 for one cycle and l1_rdata=B; no entry installed.
3. Fill 4 dirty entries 0x1000/0x2000/0x3000/0x4000, then dirty write 0x5000 → pmem_write of 0x1000 with its data; after pmem_resp, l1_resp=1 and 0x5000 is resident dirty.
4. 4 dirty entries, then clean eviction 0x6000 → inserted in one cycle; WB_DRAIN writes old 0x1000; a following l1_read 0x7000 stalls until drain completes, then MISS_READ.
5. Touch order (read-hit reinsertion of 0x2000) changes LRU → next forced replacement selects the correct LRU way.
6. Assert rst_n low mid MISS_READ → all outputs 0 immediately, all entries invalid, state IDLE after release.
